// File: rtl/zoh_upsampler_if.sv
// Sample-stream bundle for zoh_upsampler: input sample side with its per-sample
// hold controls, and the output beat side with burst markers.
// master = sample source / beat sink environment, slave = the upsampler itself.
interface zoh_upsampler_if #(
    parameter int DATA_W = 12,
    parameter int HOLD_W = 4
);
    // Input sample side
    logic [HOLD_W-1:0]        i_hold_len;
    logic                     i_mode;
    logic                     s_valid;
    logic                     s_ready;
    logic signed [DATA_W-1:0] s_I;
    logic signed [DATA_W-1:0] s_Q;

    // Output beat side
    logic                     m_valid;
    logic                     m_ready;
    logic signed [DATA_W-1:0] m_I;
    logic signed [DATA_W-1:0] m_Q;
    logic                     m_first;
    logic                     m_last;

    modport master (
        output i_hold_len, i_mode, s_valid, s_I, s_Q, m_ready,
        input  s_ready, m_valid, m_I, m_Q, m_first, m_last
    );

    modport slave (
        input  i_hold_len, i_mode, s_valid, s_I, s_Q, m_ready,
        output s_ready, m_valid, m_I, m_Q, m_first, m_last
    );
endinterface

// File: rtl/zoh_upsampler.sv
// Zero-order-hold / zero-stuff upsampler for I/Q samples. Every accepted sample
// becomes a burst of L output beats (L chosen per sample). An output stage plus a
// one-entry pending buffer lets consecutive bursts run back-to-back. All outputs
// are registered: next-state is computed combinationally, and the output
// registers are loaded from the *next* stage contents so they line up with it.
module zoh_upsampler #(
    parameter int DATA_W   = 12,
    parameter int HOLD_MAX = 8,
    parameter int HOLD_W   = $clog2(HOLD_MAX + 1)
) (
    input  logic             clk,
    input  logic             rst,
    zoh_upsampler_if.slave   bus
);

    localparam logic [HOLD_W-1:0] L_MAX = HOLD_W'(HOLD_MAX);
    localparam logic [HOLD_W-1:0] L_ONE = HOLD_W'(1);

    typedef enum logic [0:0] {
        StEmpty,
        StEmit
    } state_t;

    // Output stage
    state_t                   r_state, w_state;
    logic signed [DATA_W-1:0] r_cur_i, w_cur_i;
    logic signed [DATA_W-1:0] r_cur_q, w_cur_q;
    logic [HOLD_W-1:0]        r_cur_len, w_cur_len;
    logic                     r_cur_mode, w_cur_mode;
    logic [HOLD_W-1:0]        r_idx, w_idx;

    // Pending buffer
    logic                     r_pend_vld, w_pend_vld;
    logic signed [DATA_W-1:0] r_pend_i, w_pend_i;
    logic signed [DATA_W-1:0] r_pend_q, w_pend_q;
    logic [HOLD_W-1:0]        r_pend_len, w_pend_len;
    logic                     r_pend_mode, w_pend_mode;

    // Registered outputs
    logic                     r_s_ready, w_s_ready;
    logic                     r_m_valid, w_m_valid;
    logic signed [DATA_W-1:0] r_m_i, w_m_i;
    logic signed [DATA_W-1:0] r_m_q, w_m_q;
    logic                     r_m_first, w_m_first;
    logic                     r_m_last, w_m_last;

    // Handshake qualifiers
    logic                     w_in_fire;
    logic                     w_out_fire;
    logic                     w_at_last;
    logic [HOLD_W-1:0]        w_in_len;
    logic                     w_zero_beat;

    assign w_in_fire  = bus.s_valid && r_s_ready;
    assign w_out_fire = r_m_valid && bus.m_ready;
    assign w_at_last  = (r_idx == (r_cur_len - L_ONE));

    // Clamp the requested hold length into 1..HOLD_MAX
    always_comb begin
        if (bus.i_hold_len == '0) begin
            w_in_len = L_ONE;
        end else if (bus.i_hold_len > L_MAX) begin
            w_in_len = L_MAX;
        end else begin
            w_in_len = bus.i_hold_len;
        end
    end

    // Next state of the output stage and pending buffer
    always_comb begin
        w_state     = r_state;
        w_cur_i     = r_cur_i;
        w_cur_q     = r_cur_q;
        w_cur_len   = r_cur_len;
        w_cur_mode  = r_cur_mode;
        w_idx       = r_idx;
        w_pend_vld  = r_pend_vld;
        w_pend_i    = r_pend_i;
        w_pend_q    = r_pend_q;
        w_pend_len  = r_pend_len;
        w_pend_mode = r_pend_mode;

        unique case (r_state)
            StEmpty: begin
                if (w_in_fire) begin
                    w_cur_i    = bus.s_I;
                    w_cur_q    = bus.s_Q;
                    w_cur_len  = w_in_len;
                    w_cur_mode = bus.i_mode;
                    w_idx      = '0;
                    w_state    = StEmit;
                end
            end
            StEmit: begin
                if (w_out_fire && w_at_last) begin
                    if (r_pend_vld) begin
                        // s_ready is low while pending is full, so no input races this
                        w_cur_i    = r_pend_i;
                        w_cur_q    = r_pend_q;
                        w_cur_len  = r_pend_len;
                        w_cur_mode = r_pend_mode;
                        w_idx      = '0;
                        w_pend_vld = 1'b0;
                    end else if (w_in_fire) begin
                        // Bypass pending so back-to-back bursts have no bubble
                        w_cur_i    = bus.s_I;
                        w_cur_q    = bus.s_Q;
                        w_cur_len  = w_in_len;
                        w_cur_mode = bus.i_mode;
                        w_idx      = '0;
                    end else begin
                        w_idx   = '0;
                        w_state = StEmpty;
                    end
                end else begin
                    if (w_out_fire) begin
                        w_idx = r_idx + L_ONE;
                    end
                    if (w_in_fire) begin
                        w_pend_vld  = 1'b1;
                        w_pend_i    = bus.s_I;
                        w_pend_q    = bus.s_Q;
                        w_pend_len  = w_in_len;
                        w_pend_mode = bus.i_mode;
                    end
                end
            end
            default: begin
                w_state = StEmpty;
            end
        endcase
    end

    // Output values derived from the next stage contents
    always_comb begin
        w_s_ready   = !w_pend_vld;
        w_m_valid   = (w_state == StEmit);
        w_zero_beat = w_cur_mode && (w_idx != '0);
        if (w_m_valid && !w_zero_beat) begin
            w_m_i = w_cur_i;
            w_m_q = w_cur_q;
        end else begin
            w_m_i = '0;
            w_m_q = '0;
        end
        w_m_first = w_m_valid && (w_idx == '0);
        w_m_last  = w_m_valid && (w_idx == (w_cur_len - L_ONE));
    end

    // State and registered outputs; synchronous reset discards any burst in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= StEmpty;
            r_cur_i     <= '0;
            r_cur_q     <= '0;
            r_cur_len   <= L_ONE;
            r_cur_mode  <= 1'b0;
            r_idx       <= '0;
            r_pend_vld  <= 1'b0;
            r_pend_i    <= '0;
            r_pend_q    <= '0;
            r_pend_len  <= L_ONE;
            r_pend_mode <= 1'b0;
            r_s_ready   <= 1'b0;
            r_m_valid   <= 1'b0;
            r_m_i       <= '0;
            r_m_q       <= '0;
            r_m_first   <= 1'b0;
            r_m_last    <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_cur_i     <= w_cur_i;
            r_cur_q     <= w_cur_q;
            r_cur_len   <= w_cur_len;
            r_cur_mode  <= w_cur_mode;
            r_idx       <= w_idx;
            r_pend_vld  <= w_pend_vld;
            r_pend_i    <= w_pend_i;
            r_pend_q    <= w_pend_q;
            r_pend_len  <= w_pend_len;
            r_pend_mode <= w_pend_mode;
            r_s_ready   <= w_s_ready;
            r_m_valid   <= w_m_valid;
            r_m_i       <= w_m_i;
            r_m_q       <= w_m_q;
            r_m_first   <= w_m_first;
            r_m_last    <= w_m_last;
        end
    end

    assign bus.s_ready = r_s_ready;
    assign bus.m_valid = r_m_valid;
    assign bus.m_I     = r_m_i;
    assign bus.m_Q     = r_m_q;
    assign bus.m_first = r_m_first;
    assign bus.m_last  = r_m_last;

endmodule

// File: tb/tb_zoh_upsampler.sv
// Scoreboard bench for zoh_upsampler: each accepted sample pushes its expected
// burst; every presented output beat is compared against the queue head.
module tb_zoh_upsampler;

    localparam int DATA_W   = 12;
    localparam int HOLD_MAX = 8;
    localparam int HOLD_W   = 4;

    logic clk;
    logic rst;

    zoh_upsampler_if #(.DATA_W(DATA_W), .HOLD_W(HOLD_W)) bus ();

    zoh_upsampler #(
        .DATA_W  (DATA_W),
        .HOLD_MAX(HOLD_MAX),
        .HOLD_W  (HOLD_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_bad = 0;
    int cyc = 0;
    int pops = 0;
    int span_start = -1;
    int span_end = -1;
    int mon_eff;
    logic [31:0] sb[$];
    bit rnd_done;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] pack_beat(input logic [11:0] i, input logic [11:0] q,
                                              input logic f, input logic l);
        return {6'b0, i, q, f, l};
    endfunction

    function automatic logic [31:0] pack_all();
        return {4'b0, bus.m_valid, bus.s_ready, bus.m_I, bus.m_Q, bus.m_first, bus.m_last};
    endfunction

    // Monitor: compare presented beats, then record newly accepted samples
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            sb.delete();
        end else begin
            if (bus.m_valid) begin
                if (sb.size() == 0) begin
                    check("extra_beat", 32'd1, 32'd0);
                end else begin
                    check("beat", pack_beat(bus.m_I, bus.m_Q, bus.m_first, bus.m_last), sb[0]);
                    if (bus.m_ready) begin
                        void'(sb.pop_front());
                        pops++;
                        if (span_start < 0) span_start = cyc;
                        span_end = cyc;
                    end
                end
            end
            if (bus.s_valid && bus.s_ready) begin
                if (bus.i_hold_len == 0) mon_eff = 1;
                else if (int'(bus.i_hold_len) > HOLD_MAX) mon_eff = HOLD_MAX;
                else mon_eff = int'(bus.i_hold_len);
                for (int b = 0; b < mon_eff; b++) begin
                    sb.push_back(pack_beat((bus.i_mode && b != 0) ? 12'd0 : bus.s_I,
                                           (bus.i_mode && b != 0) ? 12'd0 : bus.s_Q,
                                           b == 0, b == mon_eff - 1));
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one sample; entered and left just after a rising edge
    task automatic send(input int i, input int q, input int len, input int mode);
        int t = 0;
        logic [31:0] vi, vq, vl;
        vi = i;
        vq = q;
        vl = len;
        bus.s_valid    = 1'b1;
        bus.s_I        = vi[11:0];
        bus.s_Q        = vq[11:0];
        bus.i_hold_len = vl[3:0];
        bus.i_mode     = mode[0];
        forever begin
            @(negedge clk);
            if (bus.s_ready) break;
            t++;
            if (t > 1000) begin
                check("send_timeout", 32'd1, 32'd0);
                break;
            end
        end
        step();
        bus.s_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        int t = 0;
        while (sb.size() != 0 && t < 2000) begin
            @(negedge clk);
            t++;
        end
        check({tag, "_drain"}, sb.size(), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;
        int t;
        rst            = 1'b1;
        bus.s_valid    = 1'b0;
        bus.s_I        = '0;
        bus.s_Q        = '0;
        bus.i_hold_len = '0;
        bus.i_mode     = 1'b0;
        bus.m_ready    = 1'b1;
        repeat (3) step();
        @(negedge clk);
        check("reset_outputs", pack_all(), 32'd0);
        step();
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("sready_after_reset", {31'd0, bus.s_ready}, 32'd1);
        step();

        // L=8 hold, two samples back-to-back
        p0 = pops;
        span_start = -1;
        send(100, -50, 8, 0);
        send(7, 3, 8, 0);
        @(negedge clk);
        check("t1_sready_pending", {31'd0, bus.s_ready}, 32'd0);
        drain("t1");
        check("t1_beats", pops - p0, 32'd16);
        check("t1_gapfree", span_end - span_start, 32'd15);
        step();

        // L=4 zero-stuff single sample
        p0 = pops;
        send(-2048, 2047, 4, 1);
        drain("t2");
        check("t2_beats", pops - p0, 32'd4);
        @(negedge clk);
        check("t2_idle", {31'd0, bus.m_valid}, 32'd0);
        step();

        // L=1 full-rate pass-through
        p0 = pops;
        span_start = -1;
        for (int k = 1; k <= 20; k++) send(k, -k, 1, 0);
        drain("t3");
        check("t3_beats", pops - p0, 32'd20);
        check("t3_gapfree", span_end - span_start, 32'd19);
        step();

        // L=3 with ~30% downstream stalls
        p0 = pops;
        rnd_done = 1'b0;
        fork
            begin
                for (int k = 0; k < 50; k++) begin
                    send(int'($urandom_range(4095)) - 2048, int'($urandom_range(4095)) - 2048,
                         3, 0);
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    step();
                    bus.m_ready = ($urandom_range(99) >= 30);
                end
            end
        join
        bus.m_ready = 1'b1;
        drain("t4");
        check("t4_beats", pops - p0, 32'd150);
        step();

        // Length clamping, and hold controls changed mid-burst
        p0 = pops;
        send(11, 22, 0, 0);
        send(33, 44, 15, 0);
        bus.i_hold_len = 4'd3;
        bus.i_mode     = 1'b1;
        drain("t5");
        check("t5_beats", pops - p0, 32'd9);
        step();

        // Reset at beat 3 of an L=8 burst with a sample pending
        p0 = pops;
        send(500, -500, 8, 0);
        send(600, -600, 8, 0);
        t = 0;
        while (pops - p0 < 3 && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("t6_reach_beat3", pops - p0, 32'd3);
        step();
        rst = 1'b1;
        step();
        @(negedge clk);
        check("t6_reset_outputs", pack_all(), 32'd0);
        step();
        rst = 1'b0;
        step();
        p0 = pops;
        send(-1, 1, 2, 0);
        drain("t6");
        check("t6_beats", pops - p0, 32'd2);
        @(negedge clk);
        check("t6_no_remnant", {31'd0, bus.m_valid}, 32'd0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/zoh_upsampler.md
# zoh_upsampler

Parametrised zero-order-hold / zero-stuff upsampler for complex I/Q baseband samples. Each accepted input sample is emitted as a burst of L output beats, where the hold length L is selected per sample at run time. The block uses full valid/ready handshakes on both sides, so downstream stalls are honoured. A one-entry pending buffer lets back-to-back bursts run with no idle cycle. It sits between the sample source (mapper/decimator) and the interpolation filter/DAC feeder in the TX and RX sample paths.

## Interface
Parameters:
- DATA_W, 12, signed I and Q sample width
- HOLD_MAX, 8, maximum hold length L (≥1)
- HOLD_W, $clog2(HOLD_MAX+1), width of the hold-length input (derived)

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- i_hold_len  in  HOLD_W  requested L; sampled with each accepted sample
- i_mode  in  1  0 = hold (repeat sample), 1 = zero-stuff; sampled with each accepted sample
- s_valid  in  1  input sample valid
- s_ready  out  1  block can accept a sample
- s_I, s_Q  in  DATA_W  signed input sample
- m_valid  out  1  output beat valid
- m_ready  in  1  downstream accepts beat
- m_I, m_Q  out  DATA_W  signed output beat
- m_first  out  1  beat index 0 of a burst
- m_last  out  1  beat index L-1 of a burst

## Operation
- Input transfer: s_valid && s_ready. Output transfer: m_valid && m_ready.
- Effective L per sample: 0 → 1; > HOLD_MAX → HOLD_MAX; otherwise i_hold_len. L and mode are captured together with the sample. Later changes do not affect an in-flight burst.
- Storage: an output stage (current sample, L, mode, beat index idx) plus a one-entry pending buffer (sample, L, mode).
- States:
  - EMPTY: no m_valid. An accepted sample loads the output stage, idx=0 → EMIT.
  - EMIT: m_valid=1. idx advances on each output transfer. On the transfer with idx==L-1:
    - pending full: pending loads the output stage, idx=0, stay in EMIT.
    - pending empty and an input transfer this cycle: the new sample loads the output stage directly, stay in EMIT.
    - otherwise → EMPTY.
  - In EMIT, an input transfer not consumed by the output stage in the same cycle goes to the pending buffer.
- s_ready is 0 exactly while the pending buffer is occupied.
- Beat data by mode:
  - Hold: every beat = stored sample.
  - Zero-stuff: idx 0 = sample, idx ≥1 = 0 on both I and Q.
- m_first = (idx==0). m_last = (idx==L-1). Both are 1 when L=1.
- With m_valid=1 and m_ready=0: m_I, m_Q, m_first and m_last are held stable, and idx does not advance.
- Samples are never dropped or reordered. Output bursts appear in input acceptance order.

## Timing
- All outputs are registered.
- Reset values: s_ready=0, m_valid=0, m_I=m_Q=0, m_first=0, m_last=0. Pending buffer empty, idx=0, state EMPTY.
- s_ready=1 in the first cycle after rst deasserts.
- Latency: a sample accepted in cycle N drives m_* in cycle N+1 when the output stage is EMPTY or finishing its last beat in cycle N. Otherwise it drives m_* the cycle after the current burst's final transfer.
- Throughput: with m_ready held high, output is gap-free. 1 input sample is taken per L cycles. L=1 gives a full-rate pass-through.
- Simultaneous final output transfer and input transfer with pending empty: the sample goes straight to the output stage, and pending stays empty.
- Reset mid-burst: the partial burst and the pending sample are discarded. Outputs return to reset values in the next cycle.

## Test plan
- L=8, hold mode, m_ready=1, input (I,Q)=(100,-50) then (7,3) presented back-to-back → 8 beats of (100,-50) then 8 of (7,3) with no gap. m_first on beats 0 and 8, m_last on beats 7 and 15. s_ready low while the second sample is pending.
- L=4, zero-stuff, single sample (-2048,2047) → beats (-2048,2047),(0,0),(0,0),(0,0). m_last on beat 3, then m_valid=0.
- L=1, s_valid=1 every cycle with samples 1..20, m_ready=1 → outputs 1..20 on consecutive cycles, m_first=m_last=1 on every beat.
- L=3, random m_ready with a 30 % stall rate, 50 random samples → scoreboard matches 150 beats in order. Data is stable whenever m_valid && !m_ready. No loss occurs.
- i_hold_len=0 and i_hold_len=15 with HOLD_MAX=8 → bursts of 1 and 8 beats. Changing i_hold_len mid-burst does not alter the current burst.
- Assert rst at beat 3 of an L=8 burst with a sample pending → next cycle m_valid=0, s_ready=0. After release, the first new sample outputs correctly with no remnant beats.
